muldiv_sequencer: RTL

Multi-cycle multiply/divide controller that sits beside the single-cycle ALU and owns the HI/LO register pair. It decodes the R-type funct field presented on the ALU control input, runs MULT/MULTU/DIV/DIVU as a 32-iteration shift-add or restoring-divide sequence, and serves MFHI/MFLO/MTHI/MTLO. While a sequence is in flight it asserts a stall toward the PC/register-file write enable, interlocking any dependent HI/LO access.

---
 rtl/muldiv_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle multiply/divide controller owning the HI/LO register pair.
//   Decodes R-type funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//   MULT/DIV run a 32-iteration shift-add / restoring-divide sequence on
//   operand magnitudes, followed by one sign-fixup cycle that writes HI/LO.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op_valid          instruction in execute is valid
//   is_rtype          opcode is R-type; alu_ctrl_in then holds funct
//   alu_ctrl_in[5:0]  funct / opcode
//   rs_val, rt_val    operands (dividend/multiplicand/MT source, divisor/multiplier)
//   stall             combinational interlock while a sequence is in flight
//   busy              sequence in flight
//   done              one-cycle pulse when MULT/DIV updates HI/LO
//   div_zero          one-cycle pulse on divide by zero
//   hi, lo            architectural HI/LO
//   mf_data           combinational MFHI/MFLO read data, else 0
//
// Configuration
//   MULDIV_DIV_EN     when defined, DIV/DIVU and div_zero are implemented;
//                     otherwise those codes are ignored and div_zero is 0.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        is_rtype,
    input  logic [5:0]  alu_ctrl_in,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;        // product accumulator, or remainder:quotient
    logic [31:0] mcand;      // multiplicand, or divisor
    logic        neg_q;
    logic [63:0] acc_step;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    logic dec, is_mul, is_dv, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic start_mul, start_div, sgn;
    logic [31:0] a_mag, b_mag;

    assign dec     = op_valid && is_rtype;
    assign is_mul  = dec && (alu_ctrl_in == F_MULT || alu_ctrl_in == F_MULTU);
    assign is_mfhi = dec && (alu_ctrl_in == F_MFHI);
    assign is_mflo = dec && (alu_ctrl_in == F_MFLO);
    assign is_mthi = dec && (alu_ctrl_in == F_MTHI);
    assign is_mtlo = dec && (alu_ctrl_in == F_MTLO);
`ifdef MULDIV_DIV_EN
    logic op_div, neg_r;
    logic [31:0] div_diff;
    assign is_dv     = dec && (alu_ctrl_in == 6'h1A || alu_ctrl_in == 6'h1B);
    assign start_div = is_dv && !busy && (rt_val != '0);
`else
    assign is_dv     = 1'b0;
    assign start_div = 1'b0;
`endif
    assign start_mul = is_mul && !busy;

    // Even funct codes (0x18, 0x1A) are the signed variants.
    assign sgn   = !alu_ctrl_in[0];
    assign a_mag = (sgn && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign b_mag = (sgn && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        stall      = (is_mul || is_dv || is_mfhi || is_mflo || is_mthi || is_mtlo) && busy;
        mf_data    = is_mfhi ? hi : (is_mflo ? lo : '0);
        case (state)
            IDLE:    if (start_mul || start_div) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: shift-add multiply (right shift, multiplier in low half)
    // or restoring divide (left shift, trial subtract on the upper 33 bits).
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        acc_step = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        div_diff = acc[62:31] - mcand;
        if (op_div) begin
            if (acc[63:31] >= {1'b0, mcand}) acc_step = {div_diff, acc[30:0], 1'b1};
            else                             acc_step = {acc[62:0], 1'b0};
        end
`endif
    end

    always_comb begin
        prod   = neg_q ? (~acc + 64'd1) : acc;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
        if (op_div) begin
            res_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
            res_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_zero <= is_dv && !busy && (rt_val == '0);
`endif
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        cnt   <= '0;
                        neg_q <= sgn && (rs_val[31] ^ rt_val[31]);
`ifdef MULDIV_DIV_EN
                        op_div <= start_div;
                        neg_r  <= sgn && rs_val[31];
                        if (start_div) begin
                            mcand <= b_mag;
                            acc   <= {32'd0, a_mag};
                        end else begin
                            mcand <= a_mag;
                            acc   <= {32'd0, b_mag};
                        end
`else
                        mcand <= a_mag;
                        acc   <= {32'd0, b_mag};
`endif
                    end else if (is_mthi) begin
                        hi <= rs_val;
                    end else if (is_mtlo) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    acc <= acc_step;
                end
                FIXUP: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifndef MULDIV_DIV_EN
    assign div_zero = 1'b0;
`endif
endmodule
